alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor to the team's 8-bit combinational ALU. Performs add/subtract with a stored carry flag, bitwise logic, and multi-bit logical shifts. Shifts run over several cycles, one bit position per clock. Sits between the register file and the writeback mux and is driven by the control decoder with a START/DONE handshake.

## Interface
- W, 8: datapath width in bits, W ≥ 2 and a power of two.
- SW, $clog2(W): width of the shift-amount field, taken from INPUTB[SW-1:0].

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- START  in  1  launches an operation; sampled only when idle.
- OP  in  3  opcode, sampled with START.
- INPUTA  in  W  operand A, sampled with START.
- INPUTB  in  W  operand B or shift amount, sampled with START.
- USE_C  in  1  use the stored carry as carry-in / shift-in bit; sampled with START.
- OUT  out  W  result register; valid when DONE=1 and until the next START is accepted.
- SC_OUT  out  1  stored carry flag register.
- ZERO  out  1  combinational (OUT == 0); meaningful only when BUSY=0.
- BUSY  out  1  high while in state SHIFT.
- DONE  out  1  registered one-cycle pulse marking result valid.

## Operation
- Opcodes:
  - 000 ADD: {C,R} = A + B + cin, where cin = USE_C ? C : 0.
  - 001 SUB: {C,R} = A + ~B + cin, where cin = USE_C ? C : 1. C=1 means no borrow.
  - 010 AND: R = A & B, C unchanged.
  - 011 XOR: R = A ^ B, C unchanged.
  - 100 LSH: shift A left by k = INPUTB[SW-1:0].
  - 101 RSH: shift A right (logical) by k.
  - 110 MOVB: R = B, C unchanged.
  - 111 NOP: OUT and C unchanged, DONE still pulses.
- All arithmetic is W+1 bits wide; the upper INPUTB bits above SW-1 are ignored for shifts.
- Shift-in bit s = USE_C ? C0 : 0, where C0 is SC_OUT captured at START. Every vacated position receives s.
- Each shift step:
  - LSH: {C,R} <= {R,s}.
  - RSH: {R,C} <= {s,R}.
  - After k steps, C holds the last bit shifted out.
- k = 0: OUT = A, C unchanged.
- FSM states IDLE and SHIFT:
  - IDLE & START & OP∉{LSH,RSH}: OUT/C updated at that edge, DONE=1 the next cycle, stay IDLE.
  - IDLE & START & shift: OUT<=A, CNT<=k, latch s. If k=0, DONE=1 next cycle and stay IDLE; otherwise go to SHIFT.
  - SHIFT: one step per edge, CNT decrements. The edge at which CNT reaches 0 returns to IDLE with DONE=1 in the following cycle.
- START while BUSY=1 is ignored: no queuing, no effect on the operation in flight.
- A START in the same cycle as DONE=1 is accepted (back-to-back).
- During SHIFT, OUT shows intermediate values. Consumers use OUT only on DONE.
- Reset values: OUT=0, SC_OUT=0, ZERO=1, BUSY=0, DONE=0, state IDLE, CNT=0.
- RESET asserted mid-shift aborts immediately. No DONE is produced for the aborted operation.

## Timing
- Latency from START edge to DONE high:
  - Non-shift ops and k=0: 1 cycle.
  - Shift by k ≥ 1: k+1 cycles.
  - Worst case: W cycles (k = W-1).
- BUSY is high for exactly k cycles of a shift with k ≥ 1, and is 0 in the DONE cycle.
- DONE lasts exactly one cycle.
- OUT and SC_OUT change only on accepted-START edges, shift edges, or reset.
- No combinational path from inputs to outputs except OUT→ZERO.

## Test plan
Use W=8 for all scenarios.
- ADD 0xFF + 0x01 with USE_C=0 → OUT=0x00, SC_OUT=1, ZERO=1, DONE one cycle after START. Then ADD 0x00 + 0x00 with USE_C=1 → OUT=0x01, SC_OUT=0.
- SUB 0x05 − 0x07 with USE_C=0 → OUT=0xFE, SC_OUT=0. Then SUB 0x07 − 0x05 → OUT=0x02, SC_OUT=1. Then AND 0xF0 & 0x3C → OUT=0x30, SC_OUT still 1.
- LSH A=0xB3, B=0x03, USE_C=0 → BUSY for 3 cycles, DONE 4 cycles after START, OUT=0x98, SC_OUT=1.
- With SC_OUT=1, RSH A=0x81, B=0x01, USE_C=1 → OUT=0xC0, SC_OUT=1, DONE after 2 cycles. LSH A=0x5A, B=0x08 (k=0) → OUT=0x5A, SC_OUT unchanged, DONE after 1 cycle.
- START RSH 0xFF by 7, pulse START with an ADD during BUSY → the ADD is ignored and the result is OUT=0x01 after 8 cycles. Then assert RESET mid-way through a repeat shift → OUT=0, SC_OUT=0, BUSY=0 immediately, and no DONE.
- Issue back-to-back XOR 0xAA^0x55 then NOP, each START held high through the previous DONE cycle → two consecutive DONE pulses, OUT=0xFF retained through the NOP, ZERO=0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered W-bit ALU with stored carry flag.
// Add/subtract and logic ops finish in one clock; logical shifts step one
// bit position per clock under a small IDLE/SHIFT state machine, with a
// START/DONE handshake towards the control decoder.
module alu_seq #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [2:0]   i_op,
  input  logic [W-1:0] i_inputa,
  input  logic [W-1:0] i_inputb,
  input  logic         i_use_c,
  output logic [W-1:0] o_out,
  output logic         o_sc_out,
  output logic         o_zero,
  output logic         o_busy,
  output logic         o_done
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_LSH  = 3'b100;
  localparam logic [2:0] OP_RSH  = 3'b101;
  localparam logic [2:0] OP_MOVB = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_out;
  logic           r_c;
  logic [SW-1:0]  r_cnt;
  logic           r_s;      // shift-in bit latched at START
  logic           r_dir_l;  // 1: left shift in flight, 0: right

  logic           w_cin_add;
  logic           w_cin_sub;
  logic [W:0]     w_add;
  logic [W:0]     w_sub;
  logic [SW-1:0]  w_k;
  logic           w_shift_in;

  // Operand-side arithmetic and shift setup derived from the inputs and stored carry
  always_comb begin
    w_cin_add  = 1'b0;
    w_cin_sub  = 1'b1;
    if (i_use_c) begin
      w_cin_add = r_c;
      w_cin_sub = r_c;
    end else begin
      w_cin_add = 1'b0;
      w_cin_sub = 1'b1;
    end
    w_add      = {1'b0, i_inputa} + {1'b0, i_inputb} + {{W{1'b0}}, w_cin_add};
    w_sub      = {1'b0, i_inputa} + {1'b0, ~i_inputb} + {{W{1'b0}}, w_cin_sub};
    w_k        = i_inputb[SW-1:0];
    w_shift_in = i_use_c & r_c;
  end

  // Control FSM and datapath registers: launch on START when idle, step shifts when busy
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_s     <= 1'b0;
      r_dir_l <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            case (i_op)
              OP_ADD:  begin {r_c, r_out} <= w_add; o_done <= 1'b1; end
              OP_SUB:  begin {r_c, r_out} <= w_sub; o_done <= 1'b1; end
              OP_AND:  begin r_out <= i_inputa & i_inputb; o_done <= 1'b1; end
              OP_XOR:  begin r_out <= i_inputa ^ i_inputb; o_done <= 1'b1; end
              OP_LSH, OP_RSH: begin
                r_out   <= i_inputa;
                r_cnt   <= w_k;
                r_s     <= w_shift_in;
                r_dir_l <= (i_op == OP_LSH);
                if (w_k == '0) begin
                  o_done <= 1'b1;
                end else begin
                  r_state <= ST_SHIFT;
                end
              end
              OP_MOVB: begin r_out <= i_inputb; o_done <= 1'b1; end
              OP_NOP:  begin o_done <= 1'b1; end
              default: begin o_done <= 1'b1; end
            endcase
          end
        end
        ST_SHIFT: begin
          // START is deliberately ignored here: no queuing behind a shift
          if (r_dir_l) begin
            {r_c, r_out} <= {r_out, r_s};
          end else begin
            {r_out, r_c} <= {r_s, r_out};
          end
          r_cnt <= r_cnt - SW'(1);
          if (r_cnt == SW'(1)) begin
            r_state <= ST_IDLE;
            o_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_out    = r_out;
  assign o_sc_out = r_c;
  assign o_busy   = (r_state == ST_SHIFT);
  assign o_zero   = (r_out == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (W=8) with hand-computed results.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         use_c;
  logic [W-1:0] out;
  logic         sc_out;
  logic         zero;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.W(W)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_start  (start),
    .i_op     (op),
    .i_inputa (a),
    .i_inputb (b),
    .i_use_c  (use_c),
    .o_out    (out),
    .o_sc_out (sc_out),
    .o_zero   (zero),
    .o_busy   (busy),
    .o_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Launch one op, return cycles until DONE (bounded) and BUSY cycle count.
  task automatic run_op(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic uc, output int lat, output int nbusy);
    op = o; a = av; b = bv; use_c = uc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    nbusy = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    chk(tag, {31'd0, done}, 32'd0);
  endtask

  int lat;
  int nb;
  int ndone;

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; a = 8'd0; b = 8'd0; use_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {24'd0, out}, 32'h00);
    chk("rst_sc", {31'd0, sc_out}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD with carry out
    run_op(3'b000, 8'hFF, 8'h01, 1'b0, lat, nb);
    chk("add1_lat", lat, 32'd1);
    chk("add1_out", {24'd0, out}, 32'h00);
    chk("add1_sc", {31'd0, sc_out}, 32'd1);
    chk("add1_zero", {31'd0, zero}, 32'd1);
    idle_cycle("add1_done_1cyc");

    // ADD using stored carry
    run_op(3'b000, 8'h00, 8'h00, 1'b1, lat, nb);
    chk("add2_out", {24'd0, out}, 32'h01);
    chk("add2_sc", {31'd0, sc_out}, 32'd0);
    chk("add2_zero", {31'd0, zero}, 32'd0);

    // SUB with borrow, then without
    run_op(3'b001, 8'h05, 8'h07, 1'b0, lat, nb);
    chk("sub1_out", {24'd0, out}, 32'hFE);
    chk("sub1_sc", {31'd0, sc_out}, 32'd0);
    run_op(3'b001, 8'h07, 8'h05, 1'b0, lat, nb);
    chk("sub2_out", {24'd0, out}, 32'h02);
    chk("sub2_sc", {31'd0, sc_out}, 32'd1);

    // AND / MOVB keep the carry
    run_op(3'b010, 8'hF0, 8'h3C, 1'b0, lat, nb);
    chk("and_out", {24'd0, out}, 32'h30);
    chk("and_sc", {31'd0, sc_out}, 32'd1);
    run_op(3'b110, 8'h00, 8'h3C, 1'b0, lat, nb);
    chk("movb_out", {24'd0, out}, 32'h3C);
    chk("movb_sc", {31'd0, sc_out}, 32'd1);

    // LSH 0xB3 by 3, shift-in 0
    run_op(3'b100, 8'hB3, 8'h03, 1'b0, lat, nb);
    chk("lsh_lat", lat, 32'd4);
    chk("lsh_busy", nb, 32'd3);
    chk("lsh_busy_at_done", {31'd0, busy}, 32'd0);
    chk("lsh_out", {24'd0, out}, 32'h98);
    chk("lsh_sc", {31'd0, sc_out}, 32'd1);
    idle_cycle("lsh_done_1cyc");

    // RSH 0x81 by 1, shift-in stored carry (1)
    run_op(3'b101, 8'h81, 8'h01, 1'b1, lat, nb);
    chk("rsh_lat", lat, 32'd2);
    chk("rsh_busy", nb, 32'd1);
    chk("rsh_out", {24'd0, out}, 32'hC0);
    chk("rsh_sc", {31'd0, sc_out}, 32'd1);

    // LSH by k=0 (B=8, upper bits ignored)
    run_op(3'b100, 8'h5A, 8'h08, 1'b0, lat, nb);
    chk("k0_lat", lat, 32'd1);
    chk("k0_out", {24'd0, out}, 32'h5A);
    chk("k0_sc", {31'd0, sc_out}, 32'd1);

    // RSH 0xFF by 7 with an ADD START pulsed while busy
    op = 3'b101; a = 8'hFF; b = 8'h07; use_c = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 2) begin
        op = 3'b000; a = 8'h01; b = 8'h01; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("rsh7_lat", lat, 32'd8);
    chk("rsh7_out", {24'd0, out}, 32'h01);
    chk("rsh7_sc", {31'd0, sc_out}, 32'd1);
    idle_cycle("rsh7_no_queued_add");
    chk("rsh7_out_hold", {24'd0, out}, 32'h01);

    // Reset mid-shift
    op = 3'b101; a = 8'hFF; b = 8'h07; use_c = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("abort_out", {24'd0, out}, 32'h00);
    chk("abort_sc", {31'd0, sc_out}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_zero", {31'd0, zero}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);

    // Back-to-back XOR then NOP, START held through the DONE cycle
    op = 3'b011; a = 8'hAA; b = 8'h55; use_c = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("b2b_done1", {31'd0, done}, 32'd1);
    chk("b2b_xor_out", {24'd0, out}, 32'hFF);
    op = 3'b111; a = 8'h00; b = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done2", {31'd0, done}, 32'd1);
    chk("b2b_nop_out", {24'd0, out}, 32'hFF);
    chk("b2b_nop_zero", {31'd0, zero}, 32'd0);
    chk("b2b_nop_sc", {31'd0, sc_out}, 32'd0);
    idle_cycle("b2b_done_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
